alu_execute_sequencer: RTL and testbench
========================================

Name: alu_execute_sequencer

Overview:
- Multi-cycle execute controller for the tiny RISC-V core. It drives the combinational ALU as its initiator.
- Accepts one OP / OP-IMM instruction via valid/ready and decodes it to an alu_operations::alu_operation_t.
- Fetches operands over a single shared register-file read port, issues them to the ALU, and writes the result back.
- Sits between fetch/decode and the register file; the area-minimal single read port dictates the sequential operand fetch.

Parameters:
SUPPRESS_X0_WRITE, 1, when 1 rf_write_enable is never asserted for rd==0; when 0 the write is issued and the register file discards it.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept (high only in IDLE)
instruction  input  32  RV32I instruction word, sampled on accept
rf_read_addr  output  5  register-file read address
rf_read_data  input  32  combinational read data for rf_read_addr, same cycle
alu_operation  output  alu_operations::alu_operation_t  operation to ALU
alu_operand_1  output  32  ALU operand 1 (rs1 value)
alu_operand_2  output  32  ALU operand 2 (rs2 value or sign-extended imm)
alu_result  input  32  ALU combinational result
rf_write_enable  output  1  write strobe, one cycle
rf_write_addr  output  5  rd
rf_write_data  output  32  latched ALU result
done  output  1  one-cycle pulse: instruction retired
illegal  output  1  one-cycle pulse: instruction rejected, no writeback

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - All registered outputs are 0; alu_operation=Add.
  - instr_ready=1 once out of reset.
  - Reset mid-instruction abandons it with no write and no done.
- Handshake: accept when instr_valid && instr_ready. The instruction is latched internally and the input is ignored until the next IDLE.
- Decode (on accept):
  - opcode 0110011 → R.
  - opcode 0010011 → I.
  - Any other opcode → ILLEGAL.
- funct3 map:
  - 000: Add, or Subtract if R && funct7==0100000.
  - 001: Shift_Left_Logical.
  - 010: Set_Less_Than.
  - 011: Set_Less_Than_Unsigned.
  - 100: Xor.
  - 101: Shift_Right_Logical, or Shift_Right_Arithmetic if funct7==0100000.
  - 110: Or.
  - 111: And.
- Illegal funct7:
  - R: funct7 not 0000000, or 0100000 with funct3 not in {000,101}.
  - I: funct3=001 with imm[11:5]!=0; funct3=101 with imm[11:5] not in {0000000,0100000}.
- I immediate: sign-extended instr[31:20]. The shift amount is imm[4:0]; the ALU uses operand_2[4:0].
- States:
  - IDLE: instr_ready=1. On accept, go to READ_1, or to ILLEGAL if decode fails.
  - READ_1: rf_read_addr=rs1; operand_1 ← rf_read_data. Next is READ_2 if R, else EXECUTE with operand_2 ← imm.
  - READ_2: rf_read_addr=rs2; operand_2 ← rf_read_data. Next is EXECUTE.
  - EXECUTE: alu_* outputs stable with the decoded op and operands; result register ← alu_result. Next is WRITEBACK.
  - WRITEBACK:
    - rf_write_enable=1 (unless SUPPRESS_X0_WRITE && rd==0).
    - rf_write_addr=rd; rf_write_data=result; done=1.
    - Next is IDLE.
  - ILLEGAL: illegal=1 for one cycle, no register-file activity. Next is IDLE.
- alu_operation and alu_operand_* are registered. They hold their last values outside EXECUTE and are never X.
- rf_read_addr is 0 outside READ_1/READ_2.
- Latency, accept edge to done: R = 4 cycles, I = 3 cycles, illegal = 1 cycle to the illegal pulse.
- Throughput: one instruction per latency+1 cycles; instr_ready is low in all non-IDLE states.
- rs1==rs2 and rd==rs1 are legal. Operands are captured before writeback, so there is no hazard inside the block.
- done and illegal are never high in the same cycle.

Test Plan:
- Reset mid-EXECUTE (rst_n low 1 cycle) → no rf_write_enable and no done; next cycle all outputs are 0, instr_ready=1.
- ADD x3,x1,x2 (0x002081B3) with x1=5, x2=7 → rf_read_addr 1 then 2; alu_operation=Add; 4 cycles after accept rf_write_enable=1, addr=3, data=12, done=1.
- SUB x3,x1,x2 (0x402081B3) with x1=5, x2=7 → data=0xFFFFFFFE.
- SRAI x4,x1,4 (0x4040D213) with x1=0x80000000 → Shift_Right_Arithmetic, operand_2=0x404; 3 cycles after accept data=0xF8000000.
- ADDI x0,x1,1 (SUPPRESS_X0_WRITE=1) → done=1, rf_write_enable stays 0.
- Illegal cases → illegal pulse 1 cycle after accept, no rf_write_enable, instr_ready high next cycle:
  - LW opcode 0x0000A083.
  - R funct7=0100000 with funct3=100 (0x4020C1B3).
- Back-to-back: instr_valid held high with ADDI x1,x0,-1 (0xFFF00093) then SLTIU x2,x0,1 (0x00103113) → data 0xFFFFFFFF then 1; the second accept happens exactly one cycle after the first done.

Source files
------------

// File: rtl/alu_execute_sequencer.sv
// Multi-cycle execute controller: accepts one OP/OP-IMM instruction, fetches operands
// through a single shared register-file read port, drives the ALU and writes the result back.

package alu_operations;
    typedef enum logic [3:0] {
        Add                    = 4'd0,
        Subtract               = 4'd1,
        Shift_Left_Logical     = 4'd2,
        Set_Less_Than          = 4'd3,
        Set_Less_Than_Unsigned = 4'd4,
        Xor                    = 4'd5,
        Shift_Right_Logical    = 4'd6,
        Shift_Right_Arithmetic = 4'd7,
        Or                     = 4'd8,
        And                    = 4'd9
    } alu_operation_t;
endpackage

module alu_execute_sequencer #(
    parameter bit SUPPRESS_X0_WRITE = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           instr_valid,
    output logic                           instr_ready,
    input  logic [31:0]                    instruction,
    output logic [4:0]                     rf_read_addr,
    input  logic [31:0]                    rf_read_data,
    output alu_operations::alu_operation_t alu_operation,
    output logic [31:0]                    alu_operand_1,
    output logic [31:0]                    alu_operand_2,
    input  logic [31:0]                    alu_result,
    output logic                           rf_write_enable,
    output logic [4:0]                     rf_write_addr,
    output logic [31:0]                    rf_write_data,
    output logic                           done,
    output logic                           illegal
);
    import alu_operations::*;

    typedef enum logic [2:0] {
        IDLE,
        READ_1,
        READ_2,
        EXECUTE,
        WRITEBACK,
        ILLEGAL
    } state_t;

    state_t state, next_state;

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic           dec_is_r;
    logic           dec_is_i;
    logic           dec_bad;
    alu_operation_t dec_op;

    logic           is_r_q;
    logic [4:0]     rs1_q;
    logic [4:0]     rs2_q;
    logic [4:0]     rd_q;
    logic [31:0]    imm_q;
    alu_operation_t op_q;
    logic [31:0]    result_q;

    logic           accept;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign funct7   = instruction[31:25];
    assign dec_is_r = (opcode == 7'b0110011);
    assign dec_is_i = (opcode == 7'b0010011);
    assign accept   = instr_valid && instr_ready;

    // For OP-IMM, funct7 aliases imm[11:5], so the SRAI/SRLI split uses the same field.
    always_comb begin
        dec_op = Add;
        case (funct3)
            3'b000:  dec_op = (dec_is_r && funct7 == 7'b0100000) ? Subtract : Add;
            3'b001:  dec_op = Shift_Left_Logical;
            3'b010:  dec_op = Set_Less_Than;
            3'b011:  dec_op = Set_Less_Than_Unsigned;
            3'b100:  dec_op = Xor;
            3'b101:  dec_op = (funct7 == 7'b0100000) ? Shift_Right_Arithmetic : Shift_Right_Logical;
            3'b110:  dec_op = Or;
            default: dec_op = And;
        endcase
    end

    always_comb begin
        dec_bad = 1'b0;
        if (dec_is_r) begin
            dec_bad = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
        end else if (dec_is_i) begin
            dec_bad = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                      ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
        end else begin
            dec_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        instr_ready     = 1'b0;
        rf_read_addr    = 5'd0;
        rf_write_enable = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    next_state = dec_bad ? ILLEGAL : READ_1;
                end
            end
            READ_1: begin
                rf_read_addr = rs1_q;
                next_state   = is_r_q ? READ_2 : EXECUTE;
            end
            READ_2: begin
                rf_read_addr = rs2_q;
                next_state   = EXECUTE;
            end
            EXECUTE: begin
                next_state = WRITEBACK;
            end
            WRITEBACK: begin
                rf_write_enable = !(SUPPRESS_X0_WRITE && (rd_q == 5'd0));
                done            = 1'b1;
                next_state      = IDLE;
            end
            ILLEGAL: begin
                illegal    = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The ALU-facing operation is only updated on entry to EXECUTE so it never glitches mid-fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_r_q        <= 1'b0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            rd_q          <= 5'd0;
            imm_q         <= 32'd0;
            op_q          <= Add;
            result_q      <= 32'd0;
            alu_operation <= Add;
            alu_operand_1 <= 32'd0;
            alu_operand_2 <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !dec_bad) begin
                        is_r_q <= dec_is_r;
                        rs1_q  <= instruction[19:15];
                        rs2_q  <= instruction[24:20];
                        rd_q   <= instruction[11:7];
                        imm_q  <= {{20{instruction[31]}}, instruction[31:20]};
                        op_q   <= dec_op;
                    end
                end
                READ_1: begin
                    alu_operand_1 <= rf_read_data;
                    if (!is_r_q) begin
                        alu_operand_2 <= imm_q;
                        alu_operation <= op_q;
                    end
                end
                READ_2: begin
                    alu_operand_2 <= rf_read_data;
                    alu_operation <= op_q;
                end
                EXECUTE: begin
                    result_q <= alu_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign rf_write_addr = rd_q;
    assign rf_write_data = result_q;

endmodule

// File: tb/tb_alu_execute_sequencer.sv
// Directed bench for alu_execute_sequencer with a register-file model and a reference ALU.

module tb_alu_execute_sequencer;
    import alu_operations::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           instr_valid = 1'b0;
    logic           instr_ready;
    logic [31:0]    instruction = 32'd0;
    logic [4:0]     rf_read_addr;
    logic [31:0]    rf_read_data;
    alu_operation_t alu_operation;
    logic [31:0]    alu_operand_1;
    logic [31:0]    alu_operand_2;
    logic [31:0]    alu_result;
    logic           rf_write_enable;
    logic [4:0]     rf_write_addr;
    logic [31:0]    rf_write_data;
    logic           done;
    logic           illegal;

    int compareCount = 0;
    int failCount = 0;

    logic [31:0] regs [32];
    logic        preEn = 1'b0;
    logic [4:0]  preAddr = 5'd0;
    logic [31:0] preData = 32'd0;

    int          obsLat;
    logic        obsDone, obsIll, obsWe, obsWeSeen, obsReadyAfter, obsPulseAfter;
    logic [4:0]  obsWa, obsRead1, obsRead2;
    logic [31:0] obsWd, obsOp1, obsOp2;
    alu_operation_t obsOp;

    alu_execute_sequencer #(.SUPPRESS_X0_WRITE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .alu_operation(alu_operation), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_result(alu_result),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Register file model: x0 reads as zero, preload port shares the write process.
    always @(posedge clk) begin
        if (preEn) regs[preAddr] <= preData;
        else if (rf_write_enable) regs[rf_write_addr] <= rf_write_data;
    end
    assign rf_read_data = (rf_read_addr == 5'd0) ? 32'd0 : regs[rf_read_addr];

    always_comb begin
        alu_result = 32'd0;
        case (alu_operation)
            Add:                    alu_result = alu_operand_1 + alu_operand_2;
            Subtract:               alu_result = alu_operand_1 - alu_operand_2;
            Shift_Left_Logical:     alu_result = alu_operand_1 << alu_operand_2[4:0];
            Set_Less_Than:          alu_result = ($signed(alu_operand_1) < $signed(alu_operand_2)) ? 32'd1 : 32'd0;
            Set_Less_Than_Unsigned: alu_result = (alu_operand_1 < alu_operand_2) ? 32'd1 : 32'd0;
            Xor:                    alu_result = alu_operand_1 ^ alu_operand_2;
            Shift_Right_Logical:    alu_result = alu_operand_1 >> alu_operand_2[4:0];
            Shift_Right_Arithmetic: alu_result = $unsigned($signed(alu_operand_1) >>> alu_operand_2[4:0]);
            Or:                     alu_result = alu_operand_1 | alu_operand_2;
            And:                    alu_result = alu_operand_1 & alu_operand_2;
            default:                alu_result = 32'd0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setReg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        preAddr = a; preData = d; preEn = 1'b1;
        @(negedge clk);
        preEn = 1'b0;
    endtask

    // Offers one instruction, then observes each cycle after the accept edge until done/illegal.
    task automatic applyStimulus(input logic [31:0] instr);
        int waitCount;
        waitCount = 0;
        @(negedge clk);
        instruction = instr;
        instr_valid = 1'b1;
        while (!instr_ready && waitCount < 20) begin
            @(negedge clk);
            waitCount++;
        end
        if (!instr_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        instruction = 32'd0;
        obsLat = 0; obsDone = 0; obsIll = 0; obsWe = 0; obsWeSeen = 0;
        obsRead1 = 0; obsRead2 = 0; obsWa = 0; obsWd = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) obsRead1 = rf_read_addr;
            if (c == 2) obsRead2 = rf_read_addr;
            if (rf_write_enable) obsWeSeen = 1'b1;
            if (done || illegal) begin
                obsLat = c; obsDone = done; obsIll = illegal; obsWe = rf_write_enable;
                obsWa = rf_write_addr; obsWd = rf_write_data;
                break;
            end
            obsOp = alu_operation; obsOp1 = alu_operand_1; obsOp2 = alu_operand_2;
            @(negedge clk);
        end
        if (obsLat == 0) checkOutput("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        obsReadyAfter = instr_ready;
        obsPulseAfter = done | illegal;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(instr_ready), 32'd1);
        checkOutput({tag, "_raddr"}, 32'(rf_read_addr), 32'd0);
        checkOutput({tag, "_op"}, 32'(alu_operation), 32'(Add));
        checkOutput({tag, "_opnd1"}, alu_operand_1, 32'd0);
        checkOutput({tag, "_opnd2"}, alu_operand_2, 32'd0);
        checkOutput({tag, "_we"}, 32'(rf_write_enable), 32'd0);
        checkOutput({tag, "_waddr"}, 32'(rf_write_addr), 32'd0);
        checkOutput({tag, "_wdata"}, rf_write_data, 32'd0);
        checkOutput({tag, "_pulses"}, 32'({done, illegal}), 32'd0);
    endtask

    initial begin
        logic weSeen, doneSeen;
        int done1Cycle, done2Cycle, acceptCycle;
        logic [31:0] data1, data2;
        logic [4:0] addr2;

        $display("[TB] start");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkIdleOutputs("reset");

        setReg(5'd1, 32'd5);
        setReg(5'd2, 32'd7);

        applyStimulus(32'h002081B3);
        checkOutput("add_read1", 32'(obsRead1), 32'd1);
        checkOutput("add_read2", 32'(obsRead2), 32'd2);
        checkOutput("add_op", 32'(obsOp), 32'(Add));
        checkOutput("add_opnds", {obsOp1[15:0], obsOp2[15:0]}, {16'd5, 16'd7});
        checkOutput("add_latency", 32'(obsLat), 32'd4);
        checkOutput("add_we", 32'(obsWe), 32'd1);
        checkOutput("add_waddr", 32'(obsWa), 32'd3);
        checkOutput("add_wdata", obsWd, 32'd12);
        checkOutput("add_after", 32'({obsReadyAfter, obsPulseAfter}), 32'b10);

        applyStimulus(32'h402081B3);
        checkOutput("sub_op", 32'(obsOp), 32'(Subtract));
        checkOutput("sub_wdata", obsWd, 32'hFFFFFFFE);
        checkOutput("sub_done", 32'({obsDone, obsIll}), 32'b10);

        // Reset held for one cycle while the ADD sits in EXECUTE
        @(negedge clk);
        instruction = 32'h002081B3;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstmid_opnd1_live", alu_operand_1, 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        checkIdleOutputs("rstmid");
        rst_n = 1'b1;
        weSeen = 1'b0;
        doneSeen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rf_write_enable) weSeen = 1'b1;
            if (done) doneSeen = 1'b1;
        end
        checkOutput("rstmid_no_write", 32'(weSeen), 32'd0);
        checkOutput("rstmid_no_done", 32'(doneSeen), 32'd0);

        setReg(5'd1, 32'h80000000);
        applyStimulus(32'h4040D213);
        checkOutput("srai_op", 32'(obsOp), 32'(Shift_Right_Arithmetic));
        checkOutput("srai_opnd2", obsOp2, 32'h00000404);
        checkOutput("srai_latency", 32'(obsLat), 32'd3);
        checkOutput("srai_waddr", 32'(obsWa), 32'd4);
        checkOutput("srai_wdata", obsWd, 32'hF8000000);

        applyStimulus(32'h00108013);
        checkOutput("addi_x0_done", 32'(obsDone), 32'd1);
        checkOutput("addi_x0_we", 32'({obsWe, obsWeSeen}), 32'd0);
        checkOutput("addi_x0_wdata", obsWd, 32'h80000001);

        applyStimulus(32'h0000A083);
        checkOutput("lw_latency", 32'(obsLat), 32'd1);
        checkOutput("lw_pulse", 32'({obsIll, obsDone, obsWeSeen}), 32'b100);
        checkOutput("lw_after", 32'({obsReadyAfter, obsPulseAfter}), 32'b10);

        applyStimulus(32'h4020C1B3);
        checkOutput("rbad_latency", 32'(obsLat), 32'd1);
        checkOutput("rbad_pulse", 32'({obsIll, obsDone, obsWeSeen}), 32'b100);
        checkOutput("rbad_after", 32'({obsReadyAfter, obsPulseAfter}), 32'b10);

        // Back-to-back with instr_valid held high
        done1Cycle = 0; done2Cycle = 0; acceptCycle = 0;
        data1 = 32'd0; data2 = 32'd0; addr2 = 5'd0;
        @(negedge clk);
        instruction = 32'hFFF00093;
        instr_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (acceptCycle != 0) instr_valid = 1'b0;
            if (c == 1) instruction = 32'h00103113;
            if (done && done1Cycle == 0) begin
                done1Cycle = c; data1 = rf_write_data;
            end else if (done && done2Cycle == 0) begin
                done2Cycle = c; data2 = rf_write_data; addr2 = rf_write_addr;
            end
            if (instr_valid && instr_ready && acceptCycle == 0) acceptCycle = c;
        end
        instr_valid = 1'b0;
        checkOutput("b2b_done1_cycle", 32'(done1Cycle), 32'd3);
        checkOutput("b2b_data1", data1, 32'hFFFFFFFF);
        checkOutput("b2b_accept2_cycle", 32'(acceptCycle), 32'd4);
        checkOutput("b2b_done2_cycle", 32'(done2Cycle), 32'd7);
        checkOutput("b2b_data2", data2, 32'd1);
        checkOutput("b2b_addr2", 32'(addr2), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
